// File: rtl/palette_pkg.sv
// Shared definitions for the palette write controller.
// Register selects, widths, FIFO entry layout and FSM state codes.
package palette_pkg;

    localparam int ADDR_W  = 8;
    localparam int COLOR_W = 16;
    localparam int ENTRY_W = ADDR_W + COLOR_W;

    localparam logic [1:0] SEL_INDEX   = 2'd0;
    localparam logic [1:0] SEL_DATA_LO = 2'd1;
    localparam logic [1:0] SEL_DATA_HI = 2'd2;
    localparam logic [1:0] SEL_FILL    = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] data;
    } pal_entry_t;

    // Fill length byte: 0 encodes a full 256-entry sweep.
    function automatic logic [ADDR_W:0] fill_len(
        input logic [ADDR_W-1:0] b
    );
        if (b == '0) begin
            return {1'b1, {ADDR_W{1'b0}}};
        end
        return {1'b0, b};
    endfunction

endpackage

// File: rtl/palette_wr_fifo.sv
// Synchronous circular-buffer FIFO for buffered host palette writes.
// Ports: clk, nrst (async low), push/din, pop/dout (head), full, empty.
module palette_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged on the current count, so a push at
    // full is dropped even if a pop happens in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/palette_ctrl.sv
// Palette RAM write sequencer: host byte registers, write FIFO, fill engine.
// Ports: clk, nrst, host_wr/host_sel/host_data, blank -> busy, fifo_full,
//        overflow, pal_wr (low = write), pal_wr_addr, pal_wr_data.
module palette_ctrl
    import palette_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               host_wr,
    input  logic [1:0]         host_sel,
    input  logic [7:0]         host_data,
    input  logic               blank,
    output logic               busy,
    output logic               fifo_full,
    output logic               overflow,
    output logic               pal_wr,
    output logic [ADDR_W-1:0]  pal_wr_addr,
    output logic [COLOR_W-1:0] pal_wr_data
);

    logic [ADDR_W-1:0]  index;
    logic [7:0]         lo_latch;
    logic [COLOR_W-1:0] last_color;
    logic [COLOR_W-1:0] fill_color;
    logic [ADDR_W-1:0]  fill_addr;
    logic [ADDR_W:0]    fill_cnt;
    logic [0:0]         state;

    logic               sel_index;
    logic               sel_lo;
    logic               sel_hi;
    logic               sel_fill;
    logic               push_ok;
    logic               fill_ok;
    logic               perm;
    logic               do_pop;
    logic               do_fill;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;
    pal_entry_t         push_entry;
    pal_entry_t         head;

    assign sel_index = ~host_wr & (host_sel == SEL_INDEX);
    assign sel_lo    = ~host_wr & (host_sel == SEL_DATA_LO);
    assign sel_hi    = ~host_wr & (host_sel == SEL_DATA_HI);
    assign sel_fill  = ~host_wr & (host_sel == SEL_FILL);

    assign push_entry.addr = index;
    assign push_entry.data = {host_data, lo_latch};

    assign push_ok = sel_hi & ~fifo_full;
    assign fill_ok = sel_fill & (state == ST_IDLE) & fifo_empty;

    // Host FIFO always wins; the fill only uses otherwise idle slots.
    assign perm    = blank | ~BLANK_ONLY;
    assign do_pop  = ~fifo_empty & perm;
    assign do_fill = ~do_pop & (state == ST_FILL) & perm;

    assign head = pal_entry_t'(fifo_dout);
    assign busy = ~fifo_empty | (state == ST_FILL);

    palette_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (sel_hi),
        .din   (push_entry),
        .pop   (do_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Host register file.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            index      <= '0;
            lo_latch   <= '0;
            last_color <= '0;
            overflow   <= 1'b0;
        end else begin
            unique case (1'b1)
                sel_index: begin
                    index    <= host_data;
                    overflow <= 1'b0;
                end
                sel_lo: begin
                    lo_latch <= host_data;
                end
                sel_hi: begin
                    if (push_ok) begin
                        last_color <= push_entry.data;
                        index      <= index + 8'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                sel_fill: begin
                    if (!fill_ok) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Fill engine FSM.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            fill_addr  <= '0;
            fill_cnt   <= '0;
            fill_color <= '0;
        end else if (fill_ok) begin
            state      <= ST_FILL;
            fill_addr  <= index;
            fill_cnt   <= fill_len(host_data);
            fill_color <= last_color;
        end else if (do_fill) begin
            fill_addr <= fill_addr + 8'd1;
            fill_cnt  <= fill_cnt - 9'd1;
            if (fill_cnt == 9'd1) begin
                state <= ST_IDLE;
            end
        end
    end

    // Registered palette write port; address/data hold when idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pal_wr      <= 1'b1;
            pal_wr_addr <= '0;
            pal_wr_data <= '0;
        end else if (do_pop) begin
            pal_wr      <= 1'b0;
            pal_wr_addr <= head.addr;
            pal_wr_data <= head.data;
        end else if (do_fill) begin
            pal_wr      <= 1'b0;
            pal_wr_addr <= fill_addr;
            pal_wr_data <= fill_color;
        end else begin
            pal_wr <= 1'b1;
        end
    end

endmodule

// File: doc/palette_ctrl.md
Name: palette_ctrl

Overview:
- Sequences all writes into the 256x16 palette RAM write port (wr / wr_addr / wr_data).
- Host side is a VGA-DAC-style byte register interface: set index, write color low byte, then high byte. Each complete color is buffered in a small FIFO, and the index auto-increments.
- A fill engine writes one color across a range of palette entries.
- An arbiter drains the FIFO (priority) and fill requests into the palette. With BLANK_ONLY=1 it does so only while video is blanked.

Parameters:
- FIFO_DEPTH, 4, host write FIFO entries; power of 2, minimum 2.
- BLANK_ONLY, 1, 1 = palette writes only when blank=1; 0 = writes whenever work is pending.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset; asynchronous, active-low
- host_wr  in  1  0=host register write this cycle, 1=idle
- host_sel  in  2  register select: 0=INDEX, 1=DATA_LO, 2=DATA_HI, 3=FILL
- host_data  in  8  host write byte
- blank  in  1  1=display blanking interval
- busy  out  1  1 while FIFO non-empty or fill active
- fifo_full  out  1  1 when FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky: a host push or fill request was dropped
- pal_wr  out  1  to palette wr; 0=write
- pal_wr_addr  out  8  to palette wr_addr
- pal_wr_data  out  16  to palette wr_data

Behaviour:
- Reset (nrst=0, async):
  - Outputs: pal_wr=1, pal_wr_addr=0, pal_wr_data=0, busy=0, fifo_full=0, overflow=0.
  - Internal: index=0, lo_latch=0, last_color=0, FIFO emptied, state=IDLE.
  - Reset mid-fill aborts the fill; no further writes are issued.
- Host register writes, sampled at posedge clk when host_wr=0:
  - INDEX: index<=host_data; overflow<=0.
  - DATA_LO: lo_latch<=host_data.
  - DATA_HI, FIFO not full: push {addr=index, data={host_data,lo_latch}}; last_color<={host_data,lo_latch}; index<=index+1, wrapping 255->0.
  - DATA_HI, FIFO full: drop the write; index and last_color unchanged; overflow<=1. Fullness is evaluated before any same-cycle pop, so a push at full is dropped even if a pop occurs in that cycle.
  - FILL, state=IDLE and FIFO empty: fill_addr<=index; fill_cnt<=host_data, where 0 means 256; state<=FILL. The index register is not modified.
  - FILL, otherwise: ignore the request; overflow<=1.
- Arbiter: permission = blank | ~BLANK_ONLY, evaluated every cycle.
  - FIFO non-empty and permission: pop the head. Registered outputs next edge: pal_wr=0, pal_wr_addr=head.addr, pal_wr_data=head.data.
  - Else state=FILL and permission: pal_wr=0, pal_wr_addr=fill_addr, pal_wr_data=last_color; fill_addr<=fill_addr+1 (8-bit wrap); fill_cnt<=fill_cnt-1. The edge that issues the last entry sets state<=IDLE.
  - Else: pal_wr=1. Address and data outputs hold their previous values.
  - At most one palette write per clock.
  - Host pushes during FILL are accepted and preempt fill writes cycle by cycle. Fill resumes when the FIFO is empty.
  - last_color is latched at the fill's start edge into fill_color; later DATA_HI writes do not change the fill color.
- Latency:
  - DATA_HI push at edge N with blank=1 and FIFO previously empty: pal_wr=0 is presented after edge N+1, and the palette captures at edge N+2.
  - blank falling stops new writes at the next edge. A write already presented completes.
- Status outputs:
  - busy = FIFO non-empty | state==FILL, registered in step with state.
  - fifo_full tracks the count.
- FIFO: standard circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1. Simultaneous push and pop when not full: the count is unchanged.
- FSM states: IDLE, FILL. Transitions:
  - IDLE->FILL on an accepted FILL request.
  - FILL->IDLE after fill_cnt entries have been issued, or on reset.

Decomposition:
- Shared package palette_pkg:
  - register-select constants SEL_INDEX/SEL_DATA_LO/SEL_DATA_HI/SEL_FILL
  - color width 16 and palette address width 8
  - FSM state encoding ST_IDLE/ST_FILL
- One sub-module, palette_wr_fifo: synchronous FIFO.
  - Parameters: DEPTH, width 24 (8-bit addr plus 16-bit data).
  - Ports: push/pop/full/empty.
  - Same clk/nrst conventions as this block.

Test Plan:
- Reset then INDEX=0x10, DATA_LO=0x34, DATA_HI=0x02 with blank=1 -> exactly one pal_wr=0 cycle, addr=0x10, data=0x0234, two edges after the DATA_HI edge. Index reads 0x11 as the next push lands at 0x11.
- blank=0, BLANK_ONLY=1, push 5 colors at index 0xFE -> first 4 accepted, fifo_full=1, 5th dropped, overflow=1, no pal_wr. Raise blank -> writes to 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles, then busy=0.
- Push color 0x0F0F, INDEX=0x20, FILL=0x03 with blank=1 -> pal_wr=0 for 3 cycles, addrs 0x20, 0x21, 0x22, data 0x0F0F, then IDLE.
- FILL=0x00 at index 0x00 -> 256 writes covering 0x00..0xFF. Toggle blank mid-fill -> writes pause while blank=0 and resume without loss or duplication.
- During an active fill, push one host color -> the host write is issued on the next permitted cycle ahead of the fill and the fill completes afterwards. A second FILL request during the fill is ignored and sets overflow=1.
- Assert nrst=0 asynchronously mid-fill with FIFO non-empty -> pal_wr=1 immediately, all outputs at reset values, no writes after release until a new host write.
